des_codec_ctrl: RTL and testbench
=================================

DES_CODEC_CTRL -- requirements
Module: des_codec_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, maximum outstanding jobs (in codec pipeline plus result FIFO); legal range 2..8.
REQ-002 Parameter: LAT, 17, fixed codec latency in cycles from codec valid_i high to codec valid_o high.
REQ-003 Port: clk  input  1  single clock; all logic on posedge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: req_valid  input  1  upstream job valid.
REQ-006 Port: req_ready  output  1  job accepted when req_valid && req_ready at posedge.
REQ-007 Port: req_data  input  [0:63]  job plaintext or ciphertext.
REQ-008 Port: req_key  input  [0:63]  job key.
REQ-009 Port: codec_valid_o  output  1  drives codec valid_i.
REQ-010 Port: codec_data_o  output  [0:63]  drives codec data_i.
REQ-011 Port: codec_key_o  output  [0:63]  drives codec key.
REQ-012 Port: codec_valid_i  input  1  codec valid_o.
REQ-013 Port: codec_data_i  input  [0:63]  codec data_o.
REQ-014 Port: rsp_valid  output  1  result available.
REQ-015 Port: rsp_ready  input  1  result consumed when rsp_valid && rsp_ready at posedge.
REQ-016 Port: rsp_data  output  [0:63]  oldest result.
REQ-017 Port: err_o  output  1  sticky protocol/latency error.

Function
REQ-018 Accept at edge k SHALL drive codec_valid_o=1 for exactly the cycle after edge k, with codec_data_o=req_data captured at edge k.
REQ-019 codec_key_o SHALL be a register loaded from req_key only on an accept while in_flight==0, and held unchanged otherwise.
REQ-020 in_flight counter (0..DEPTH) SHALL +1 on accept, -1 on codec_valid_i, and stay unchanged when both occur on the same edge.
REQ-021 req_ready SHALL be 1 only when (in_flight + fifo_cnt) < DEPTH and state != HOLD and (in_flight==0 or req_key==codec_key_o); it SHALL be combinational from state and counters only, never from req_valid.
REQ-022 FSM states: IDLE (in_flight==0), BUSY (in_flight>0), HOLD (draining for a key change).
REQ-023 IDLE->BUSY on accept; BUSY->HOLD when req_valid && req_key!=codec_key_o; BUSY->IDLE when in_flight reaches 0 with no accept in the same cycle; HOLD->IDLE when in_flight reaches 0; no accept in HOLD.
REQ-024 Result FIFO, DEPTH entries, SHALL push codec_data_i on codec_valid_i and pop on rsp handshake; rsp_valid=(fifo_cnt!=0); rsp_data=head entry; simultaneous push and pop on a full or empty FIFO SHALL be legal.
REQ-025 End-to-end latency with an empty FIFO SHALL be 18 cycles: accept at edge k, push at edge k+18, rsp_valid high after edge k+18.
REQ-026 A LAT-stage expectation shift register SHALL track codec_valid_o; if codec_valid_i differs from the expected tap on any edge, err_o SHALL set.
REQ-027 A push onto a full FIFO SHALL drop the data, leave the FIFO unchanged, and set err_o.
REQ-028 codec_valid_i with in_flight==0 SHALL set err_o and leave in_flight at 0 (no underflow).
REQ-029 err_o SHALL be sticky until reset; error conditions SHALL NOT stall or alter normal flow.
REQ-030 Credit counting SHALL count results still in the FIFO, so rsp_ready=0 throttles req_ready and no result is ever dropped in legal operation.

Reset
REQ-031 On rst_n=0, asynchronously: state=IDLE, in_flight=0, fifo_cnt=0, shift register=0, codec_valid_o=0, codec_data_o=0, codec_key_o=0, rsp_valid=0, err_o=0; req_ready=0 while rst_n=0.
REQ-032 Reset during operation SHALL discard all in-flight jobs and FIFO contents; codec outputs arriving after deassertion SHALL set err_o per REQ-028.
REQ-033 After rst_n rises, req_ready SHALL be 1 on the first clock with the FIFO empty.

Verification
REQ-034 One job: data=64'h0123456789ABCDEF, key=64'h133457799BBCDFF1, codec echoes result at +17 -> rsp_valid at accept+18, rsp_data equals codec_data_i, err_o=0.
REQ-035 Back-to-back: 4 jobs, same key, rsp_ready=0 -> 4 accepted on consecutive edges, 5th stalls (req_ready=0) until a pop; results come out in order.
REQ-036 Key change: 2 jobs with key A, then a job with key B -> HOLD entered, codec_key_o stays A for 17 cycles after the last A valid, B issued the cycle after in_flight reaches 0.
REQ-037 Latency fault: codec returns a result at +16 -> err_o=1 and stays 1; later legal jobs still complete.
REQ-038 Spurious codec_valid_i with nothing outstanding -> err_o=1, in_flight=0, FIFO unchanged.
REQ-039 rst_n pulsed low with 3 jobs in flight -> all outputs at reset values immediately; req_ready=1 on the first clock after release.

Source files
------------

// File: rtl/des_codec_ctrl_if.sv
// Job, codec and result handshake bundle for the DES codec controller.
// slave is the controller side, master is the job source / codec / result sink side.
interface des_codec_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [0:63] req_data;
  logic [0:63] req_key;
  logic        codec_valid_o;
  logic [0:63] codec_data_o;
  logic [0:63] codec_key_o;
  logic        codec_valid_i;
  logic [0:63] codec_data_i;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:63] rsp_data;

  modport slave (
    input  req_valid, req_data, req_key, codec_valid_i, codec_data_i, rsp_ready,
    output req_ready, codec_valid_o, codec_data_o, codec_key_o, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_data, req_key, codec_valid_i, codec_data_i, rsp_ready,
    input  req_ready, codec_valid_o, codec_data_o, codec_key_o, rsp_valid, rsp_data
  );
endinterface

// File: rtl/des_codec_ctrl.sv
// Issues jobs to a fixed-latency DES codec with credit flow control and key-change draining.
// Latency accept->rsp_valid is LAT+1 cycles; req_ready drops when credits run out or a key change drains.
module des_codec_ctrl #(
  parameter int DEPTH = 4,
  parameter int LAT   = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  des_codec_ctrl_if.slave  bus,
  output logic             err_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] in_flight, in_flight_nxt, fifo_cnt;
  logic [CW:0]   credits;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [0:63]   mem [DEPTH];
  logic [LAT-1:0] exp_sr;
  logic accept, pop, push_req, push, full, key_match;
  logic lat_err, drop_err, unf_err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign credits       = {1'b0, in_flight} + {1'b0, fifo_cnt};
  assign key_match     = (bus.req_key == bus.codec_key_o);
  assign bus.req_ready = rst_n && (credits < (CW+1)'(DEPTH)) && (state != HOLD) &&
                         ((in_flight == '0) || key_match);
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = (fifo_cnt != '0);
  assign bus.rsp_data  = mem[rd_ptr];
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign full          = (fifo_cnt == CW'(DEPTH));

  // A codec result with nothing outstanding is flagged but never enters the FIFO.
  assign push_req = bus.codec_valid_i && (in_flight != '0);
  assign push     = push_req && (!full || pop);
  assign unf_err  = bus.codec_valid_i && (in_flight == '0);
  assign drop_err = push_req && full && !pop;
  assign lat_err  = (bus.codec_valid_i != exp_sr[LAT-1]);

  always_comb begin
    in_flight_nxt = in_flight;
    if (accept && !push_req)
      in_flight_nxt = in_flight + CW'(1);
    else if (!accept && push_req)
      in_flight_nxt = in_flight - CW'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: begin
        if (in_flight_nxt == '0)
          state_nxt = IDLE;
        else if (bus.req_valid && !key_match)
          state_nxt = HOLD;
      end
      HOLD: if (in_flight_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      in_flight         <= '0;
      fifo_cnt          <= '0;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      exp_sr            <= '0;
      bus.codec_valid_o <= 1'b0;
      bus.codec_data_o  <= '0;
      bus.codec_key_o   <= '0;
      err_o             <= 1'b0;
    end else begin
      state             <= state_nxt;
      in_flight         <= in_flight_nxt;
      exp_sr            <= {exp_sr[LAT-2:0], bus.codec_valid_o};
      bus.codec_valid_o <= accept;
      if (accept)
        bus.codec_data_o <= bus.req_data;
      // Key only changes once the pipeline is empty.
      if (accept && (in_flight == '0))
        bus.codec_key_o <= bus.req_key;
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)
        fifo_cnt <= fifo_cnt + CW'(1);
      else if (!push && pop)
        fifo_cnt <= fifo_cnt - CW'(1);
      if (lat_err || drop_err || unf_err)
        err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.codec_data_i;
  end
endmodule

// File: tb/tb_des_codec_ctrl.sv
// Randomized and directed bench for des_codec_ctrl with a transaction-level codec and credit model.
module tb_des_codec_ctrl;
  localparam int DEPTH = 4;
  localparam int LAT   = 17;
  localparam logic [0:63] KA = 64'h133457799BBCDFF1;
  localparam logic [0:63] KB = 64'h0E329232EA6D0D73;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_o;
  always #5 clk = ~clk;

  des_codec_ctrl_if bus ();

  des_codec_ctrl #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err_o (err_o)
  );

  typedef struct packed { int due; logic [0:63] d; } ev_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  ev_t         sched [$];
  logic [0:63] exp_q [$];
  logic [0:63] iss_d [$];
  logic [0:63] iss_k [$];
  int          outst, inflight, lat_next;
  logic [0:63] key_m;
  bit          hold_m, spur, last_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behaviour of the external codec: some keyed mix of the data.
  function automatic logic [0:63] res_fn(input logic [0:63] d, input logic [0:63] k);
    return {d[32:63], d[0:31]} ^ k;
  endfunction

  task automatic step();
    bit acc, pop, rdy_exp;
    @(negedge clk);
    acc     = bus.req_valid && bus.req_ready;
    pop     = bus.rsp_valid && bus.rsp_ready;
    rdy_exp = !hold_m && (outst < DEPTH) && (inflight == 0 || bus.req_key == key_m);
    chk("req_ready", bus.req_ready, rdy_exp);
    if (bus.req_valid && inflight > 0 && bus.req_key != key_m)
      hold_m = 1;
    if (pop) begin
      chk("rsp_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("rsp_data", bus.rsp_data, exp_q.pop_front());
      outst--;
    end
    if (acc) begin
      if (inflight == 0) key_m = bus.req_key;
      exp_q.push_back(res_fn(bus.req_data, bus.req_key));
      iss_d.push_back(bus.req_data);
      iss_k.push_back(bus.req_key);
      outst++;
    end
    last_acc = acc;

    @(posedge clk);
    #1;
    cyc++;
    if (bus.codec_valid_i && inflight > 0) inflight--;
    if (inflight == 0) hold_m = 0;
    if (bus.codec_valid_o) begin
      chk("codec_issue_q", iss_d.size() != 0, 1);
      if (iss_d.size() != 0) begin
        chk("codec_data_o", bus.codec_data_o, iss_d.pop_front());
        chk("codec_key_o", bus.codec_key_o, iss_k.pop_front());
      end
      inflight++;
      sched.push_back('{due: cyc + lat_next, d: res_fn(bus.codec_data_o, bus.codec_key_o)});
      lat_next = LAT;
    end
    bus.codec_valid_i = 1'b0;
    if (sched.size() != 0 && sched[0].due == cyc) begin
      bus.codec_valid_i = 1'b1;
      bus.codec_data_i  = sched[0].d;
      void'(sched.pop_front());
    end else if (spur) begin
      bus.codec_valid_i = 1'b1;
      bus.codec_data_i  = {$urandom, $urandom};
      spur = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_codec_valid", bus.codec_valid_o, 0);
    chk("rst_codec_data", bus.codec_data_o, 0);
    chk("rst_codec_key", bus.codec_key_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_err", err_o, 0);
    sched.delete(); exp_q.delete(); iss_d.delete(); iss_k.delete();
    outst = 0; inflight = 0; key_m = '0; hold_m = 0; spur = 0; lat_next = LAT;
    bus.req_valid = 0; bus.rsp_ready = 0; bus.codec_valid_i = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("rst_release_ready", bus.req_ready, 1);
  endtask

  task automatic drain(input int n);
    bus.req_valid = 0;
    bus.rsp_ready = 1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n, cnt;
    bit ksel;
    bus.req_valid = 0; bus.req_data = '0; bus.req_key = '0;
    bus.codec_valid_i = 0; bus.codec_data_i = '0; bus.rsp_ready = 0;
    outst = 0; inflight = 0; key_m = '0; hold_m = 0; spur = 0; lat_next = LAT;
    @(posedge clk);
    #1;
    do_reset();

    // Single job, end-to-end latency
    bus.req_valid = 1; bus.req_data = 64'h0123456789ABCDEF; bus.req_key = KA;
    step();
    chk("t1_acc", last_acc, 1);
    bus.req_valid = 0;
    n = 0;
    while (!bus.rsp_valid && n < 40) begin step(); n++; end
    chk("t1_latency", n, 18);
    chk("t1_rsp_data", bus.rsp_data, res_fn(64'h0123456789ABCDEF, KA));
    drain(2);
    chk("t1_err", err_o, 0);

    // Back-to-back with the result path stalled
    bus.rsp_ready = 0; bus.req_key = KA; cnt = 0;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1; bus.req_data = {$urandom, $urandom};
      step();
      cnt += int'(last_acc);
    end
    chk("t2_acc4", cnt, 4);
    cnt = 0;
    bus.req_data = {$urandom, $urandom};
    for (int i = 0; i < 30; i++) begin step(); cnt += int'(last_acc); end
    chk("t2_stall", cnt, 0);
    bus.rsp_ready = 1;
    n = 0;
    while (!last_acc && n < 10) begin step(); n++; end
    chk("t2_resume", last_acc, 1);
    drain(40);
    chk("t2_drain", exp_q.size(), 0);

    // Key change drains the pipeline first
    bus.req_key = KA;
    for (int i = 0; i < 2; i++) begin
      bus.req_valid = 1; bus.req_data = {$urandom, $urandom};
      step();
    end
    bus.req_key = KB; bus.req_data = {$urandom, $urandom};
    n = 0;
    do begin
      step(); n++;
      if (!last_acc) chk("t3_key_held", bus.codec_key_o, KA);
    end while (!last_acc && n < 60);
    chk("t3_gap", n, 19);
    chk("t3_key_b", bus.codec_key_o, KB);
    chk("t3_issue_b", bus.codec_valid_o, 1);
    drain(40);
    chk("t3_drain", exp_q.size(), 0);

    // Early codec result, then a legal job
    lat_next = 16;
    bus.req_valid = 1; bus.req_key = KB; bus.req_data = {$urandom, $urandom};
    step();
    drain(25);
    chk("t4_err", err_o, 1);
    bus.req_valid = 1; bus.req_data = {$urandom, $urandom};
    step();
    drain(25);
    chk("t4_err_sticky", err_o, 1);
    chk("t4_drain", exp_q.size(), 0);

    // Spurious codec result with nothing outstanding
    do_reset();
    spur = 1;
    step(); step(); step();
    chk("t5_err", err_o, 1);
    chk("t5_rsp_valid", bus.rsp_valid, 0);
    chk("t5_ready", bus.req_ready, 1);

    // Reset with jobs in flight
    do_reset();
    bus.req_key = KA;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1; bus.req_data = {$urandom, $urandom};
      step();
    end
    bus.req_valid = 0;
    step(); step();
    chk("t6_inflight_before", bus.codec_key_o, KA);
    do_reset();

    // Random traffic over two keys
    ksel = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(9) == 0) ksel = ~ksel;
      bus.req_valid = ($urandom_range(9) < 7);
      bus.req_key   = ksel ? KB : KA;
      bus.req_data  = {$urandom, $urandom};
      bus.rsp_ready = ($urandom_range(9) < 6);
      step();
    end
    drain(60);
    chk("t7_drain", exp_q.size(), 0);
    chk("t7_err", err_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
